// File: rtl/dptr_pkg.sv
// Shared datapath definitions: fetch FSM states, HALT opcode and opcode field bounds.
`default_nettype none

package dptr_pkg;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;
  localparam int         OPC_MSB     = 31;
  localparam int         OPC_LSB     = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control inputs, instruction memory port and datapath-facing outputs.
`default_nettype none

interface instr_fetch_if #(
  parameter int AW = 6
);
  logic          start;
  logic          stall;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [31:0]   pc;
  logic          halted;
  logic [15:0]   fetch_count;

  modport master (
    input  start, stall, imem_rdata,
    output imem_addr, instr, instr_valid, pc, halted, fetch_count
  );

  modport slave (
    output start, stall, imem_rdata,
    input  imem_addr, instr, instr_valid, pc, halted, fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, reads a combinational-read instruction
// memory and issues one registered instruction per non-stalled RUN cycle.
`default_nettype none

module instr_fetch
  import dptr_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam logic [31:0] LAST_ADDR = 32'((IMEM_DEPTH - 1) * 4);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         halted_q;
  logic [15:0]  count_q;

  logic [31:0]  next_pc;
  logic         is_halt_word;

  // PC wraps to word 0 straight after the last word, so no bubble at the boundary.
  assign next_pc      = (pc_q == LAST_ADDR) ? 32'd0 : pc_q + 32'd4;
  assign is_halt_word = (opcode_of(bus.imem_rdata) == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= 32'd0;
      instr_q  <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          pc_q     <= 32'd0;
          instr_q  <= 32'd0;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
          if (bus.start) begin
            count_q <= 16'd0;
            state   <= RUN;
          end
        end

        RUN: begin
          // Stall freezes everything, including halt detection.
          if (!bus.stall) begin
            if (is_halt_word) begin
              instr_q  <= 32'd0;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              state    <= HALT;
            end else begin
              instr_q <= bus.imem_rdata;
              valid_q <= 1'b1;
              pc_q    <= next_pc;
              if (count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
              end
            end
          end
        end

        HALT: begin
          instr_q <= 32'd0;
          valid_q <= 1'b0;
          if (bus.start) begin
            pc_q     <= 32'd0;
            count_q  <= 16'd0;
            halted_q <= 1'b0;
            state    <= RUN;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_q[AW+1:2];
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected issues, monitors compare them.
`default_nettype none

module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst4_n;
  int   checks;
  int   errors;

  exp_t exp_q[$];
  exp_t exp4_q[$];

  logic [31:0] rom  [0:63];
  logic [31:0] rom4 [0:3];

  instr_fetch_if #(.AW(6)) bus ();
  instr_fetch_if #(.AW(2)) bus4 ();

  assign bus.imem_rdata  = rom[bus.imem_addr];
  assign bus4.imem_rdata = rom4[bus4.imem_addr];

  instr_fetch #(.IMEM_DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  instr_fetch #(.IMEM_DEPTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [15:0] c);
    exp_t e;
    e.instr = i; e.pc = p; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic push4(input logic [31:0] i, input logic [31:0] p, input logic [15:0] c);
    exp_t e;
    e.instr = i; e.pc = p; e.cnt = c;
    exp4_q.push_back(e);
  endtask

  // Monitors: every live issue must match the head of its scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.instr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", bus.instr, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("issue_instr", bus.instr, e.instr);
        chk("issue_pc", bus.pc, e.pc);
        chk("issue_count", {16'd0, bus.fetch_count}, {16'd0, e.cnt});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst4_n && bus4.instr_valid) begin
      if (exp4_q.size() == 0) begin
        chk("wrap_unexpected_issue", bus4.instr, 32'hxxxx_xxxx);
      end else begin
        e = exp4_q.pop_front();
        chk("wrap_instr", bus4.instr, e.instr);
        chk("wrap_pc", bus4.pc, e.pc);
        chk("wrap_count", {16'd0, bus4.fetch_count}, {16'd0, e.cnt});
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    int n;
    n = 0;
    while (!bus.halted && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'd0, bus.halted}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({tag, "_pc"}, bus.pc, 32'd0);
    chk({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
    chk({tag, "_count"}, {16'd0, bus.fetch_count}, 32'd0);
    chk({tag, "_imem_addr"}, {26'd0, bus.imem_addr}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; rst4_n = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0;
    bus4.start = 1'b0; bus4.stall = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0020 + i;
    rom[0] = 32'h00221820; rom[1] = 32'h00221822;
    rom[2] = 32'h00221824; rom[3] = 32'h00221825;
    rom[4] = 32'hFC000000;
    rom4[0] = 32'h00A00020; rom4[1] = 32'h00A10022;
    rom4[2] = 32'h00A20024; rom4[3] = 32'h00A30025;

    // Reset held for three cycles, then idle without start.
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset("idle_no_start");

    // Four words issued back to back, then the HALT word at word 4.
    push(32'h00221820, 32'd4, 16'd1);
    push(32'h00221822, 32'd8, 16'd2);
    push(32'h00221824, 32'd12, 16'd3);
    push(32'h00221825, 32'd16, 16'd4);
    do_start();
    wait_halted("run4_halted");
    chk("run4_pc", bus.pc, 32'd16);
    chk("run4_count", {16'd0, bus.fetch_count}, 32'd4);
    chk("run4_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("run4_instr", bus.instr, 32'd0);
    chk("run4_drained", exp_q.size(), 32'd0);

    // Two-cycle stall after the second issue holds word 1 and pc=8.
    push(32'h00221820, 32'd4, 16'd1);
    push(32'h00221822, 32'd8, 16'd2);
    push(32'h00221822, 32'd8, 16'd2);
    push(32'h00221822, 32'd8, 16'd2);
    push(32'h00221824, 32'd12, 16'd3);
    push(32'h00221825, 32'd16, 16'd4);
    do_start();
    @(posedge clk);
    @(posedge clk); #1 bus.stall = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 bus.stall = 1'b0;
    wait_halted("stall_halted");
    chk("stall_drained", exp_q.size(), 32'd0);

    // HALT word at address 2.
    rom[2] = 32'hFC000000;
    push(32'h00221820, 32'd4, 16'd1);
    push(32'h00221822, 32'd8, 16'd2);
    do_start();
    wait_halted("halt_w2_halted");
    chk("halt_w2_pc", bus.pc, 32'd8);
    chk("halt_w2_count", {16'd0, bus.fetch_count}, 32'd2);
    chk("halt_w2_valid", {31'd0, bus.instr_valid}, 32'd0);

    // Restart from HALT clears pc and count on the start edge.
    push(32'h00221820, 32'd4, 16'd1);
    push(32'h00221822, 32'd8, 16'd2);
    do_start();
    chk("restart_pc", bus.pc, 32'd0);
    chk("restart_count", {16'd0, bus.fetch_count}, 32'd0);
    chk("restart_halted", {31'd0, bus.halted}, 32'd0);
    wait_halted("restart_halted_again");

    // Stall while the HALT word is presented masks halt detection.
    push(32'h00221820, 32'd4, 16'd1);
    push(32'h00221822, 32'd8, 16'd2);
    push(32'h00221822, 32'd8, 16'd2);
    push(32'h00221822, 32'd8, 16'd2);
    push(32'h00221822, 32'd8, 16'd2);
    do_start();
    @(posedge clk);
    @(posedge clk); #1 bus.stall = 1'b1;
    chk("mask_addr", {26'd0, bus.imem_addr}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mask_not_halted", {31'd0, bus.halted}, 32'd0);
    end
    bus.stall = 1'b0;
    @(posedge clk); #1;
    chk("mask_halt_next_edge", {31'd0, bus.halted}, 32'd1);
    chk("mask_pc", bus.pc, 32'd8);
    chk("mask_drained", exp_q.size(), 32'd0);

    // Asynchronous reset between edges, mid-RUN.
    rom[2] = 32'h00221824;
    push(32'h00221820, 32'd4, 16'd1);
    push(32'h00221822, 32'd8, 16'd2);
    do_start();
    @(posedge clk);
    @(posedge clk);
    #7 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset("post_reset_idle");
    chk("async_drained", exp_q.size(), 32'd0);

    // Wrap-around on a four-word memory.
    rst4_n = 1'b1;
    push4(32'h00A00020, 32'd4, 16'd1);
    push4(32'h00A10022, 32'd8, 16'd2);
    push4(32'h00A20024, 32'd12, 16'd3);
    push4(32'h00A30025, 32'd0, 16'd4);
    push4(32'h00A00020, 32'd4, 16'd5);
    @(posedge clk); #1 bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    repeat (5) @(posedge clk);
    #6 rst4_n = 1'b0;
    #1 chk("wrap_drained", exp4_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that produces the 32-bit instruction stream consumed by the single-cycle R-type datapath. It owns the program counter, reads a synchronous-interface instruction memory, issues one registered instruction per cycle with a valid flag, and honours stall and halt. It sits between the instruction memory and the datapath's `instruccion` input.

## Interface

Parameters:
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words; power of two, ≥2.
- `AW`, `$clog2(IMEM_DEPTH)`: word-address width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; launches fetch from IDLE or HALT.
- `stall`  in  1  freezes the fetch pipeline for the cycle.
- `imem_addr`  out  AW  word address to instruction memory, equal to `pc[AW+1:2]`.
- `imem_rdata`  in  32  instruction word at `imem_addr`, combinational read.
- `instr`  out  32  registered instruction to the datapath.
- `instr_valid`  out  1  `instr` is a live instruction this cycle.
- `pc`  out  32  byte address of the next word to fetch.
- `halted`  out  1  high while in HALT.
- `fetch_count`  out  16  instructions issued since the last start; saturates at 16'hFFFF.

## Operation

- FSM states: IDLE, RUN, HALT. Reset state is IDLE.
- IDLE:
  - `pc`=0, `instr`=0, `instr_valid`=0.
  - `start`=1 moves the FSM to RUN on the next edge. `fetch_count` is cleared on that edge.
- RUN, `stall`=0, opcode `imem_rdata[31:26]` ≠ HALT_OPCODE (6'h3F):
  - `instr` ← `imem_rdata`.
  - `instr_valid` ← 1.
  - `pc` ← `pc`+4; wraps to 0 after byte address `(IMEM_DEPTH-1)*4`.
  - `fetch_count` ← `fetch_count`+1, saturating.
- RUN, `stall`=0, opcode = HALT_OPCODE:
  - The HALT word is not issued: `instr` ← 0, `instr_valid` ← 0.
  - `pc` holds at the address of the HALT word; `fetch_count` holds.
  - Next state is HALT.
- RUN, `stall`=1:
  - `instr`, `instr_valid`, `pc` and `fetch_count` all hold.
  - The opcode is not evaluated, so stall takes precedence over halt detection.
- HALT:
  - `halted`=1, `instr_valid`=0, `instr`=0; `pc` and `fetch_count` hold.
  - `start`=1 causes: `pc` ← 0, `fetch_count` ← 0, next state RUN.
- `start` is ignored in RUN.
- `stall` is ignored in IDLE and HALT.
- `rst_n` low at any time, including mid-RUN or during a stall, immediately forces:
  - state = IDLE.
  - `pc`=0, `instr`=0, `instr_valid`=0, `halted`=0, `fetch_count`=0.

## Timing

- Reset values of all outputs:
  - `instr`=32'h0, `instr_valid`=0, `pc`=32'h0, `halted`=0, `fetch_count`=0.
  - `imem_addr`=0, since it is derived from `pc`.
- `imem_addr` is combinational from `pc`, so the memory must return `imem_rdata` in the same cycle.
- Start-to-first-instruction latency: `start` sampled high at edge N gives RUN after N. The word at address 0 appears on `instr` with `instr_valid`=1 after edge N+1.
- Throughput: one instruction per non-stalled RUN cycle.
- Stall: asserting `stall` during the cycle before edge K holds all outputs across K.
- Halt latency: the HALT word fetched before edge K gives `halted`=1 and `instr_valid`=0 after K. The instruction issued before K is still consumed by the datapath in the cycle it was valid.
- Wrap-around: the fetch at word `IMEM_DEPTH-1` is followed by the fetch at word 0 with no bubble.

## Structure

- Shared package `dptr_pkg`:
  - `HALT_OPCODE` = 6'h3F.
  - Fetch-state enum {IDLE, RUN, HALT}.
  - Opcode field bounds [31:26], shared with the control unit.
- No sub-module is required; FSM, PC and counter live in one module.
- A companion `instr_mem` is used in the bench only. It is a ROM with `$readmemh` load and a combinational read.

## Test plan

- Reset then start: `rst_n` low 3 cycles, then `start`=1 for one cycle, with ROM words 0..3 = 32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825. Required: these four words appear on `instr` on consecutive cycles with `instr_valid`=1, and `pc` reads 4, 8, 12, 16.
- Stall: assert `stall` for 2 cycles after the second issue. Required: `instr`=32'h00221822 and `pc`=8 hold for 2 cycles, then the sequence resumes with 32'h00221824.
- Halt: ROM word 2 = 32'hFC000000. Required: words 0 and 1 are issued; then `halted`=1, `instr_valid`=0, `pc`=8, `fetch_count`=2. A later `start` restarts at `pc`=0 with `fetch_count`=0.
- Stall masks halt: `stall`=1 while `imem_addr`=2 holds the HALT word. Required: no transition to HALT until `stall` drops, then HALT on the next edge.
- Wrap-around with IMEM_DEPTH=4 and no HALT words. Required: `pc` sequence 4, 8, 12, 0, 4 and `fetch_count` reaching 5.
- Async reset mid-RUN: drop `rst_n` between clock edges. Required: all outputs go to reset values immediately, with no clock edge needed, and the FSM stays in IDLE until `start`.
